score_digit_render: RTL
=======================

Name: score_digit_render

Overview:
- Downstream consumer of the 3-digit BCD score counter (hundreds, tens, ones).
- Converts the three digits into a per-pixel on/off stream for the VGA colour mux.
- Draws the digits as scaled 8x16 glyphs in a fixed screen box.
- Digit values are snapshotted once per frame so a score change never tears mid-frame. Output is pipelined and aligned to the incoming pixel stream with fixed latency.

Parameters:
- X0, 560, left edge of the digit box in pixels.
- Y0, 16, top edge of the digit box in pixels.
- SCALE_LOG2, 1, glyph scale S = 2^SCALE_LOG2; legal 0..2. Box is 24*S wide by 16*S high.
- Constraints: X0+24*S <= 1024; Y0+16*S <= 1024.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- video_on  in  1  active-video flag from the sync generator, aligned with pixel_x/pixel_y.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- frame_start  in  1  single-cycle pulse at start of vertical blank.
- dig1  in  4  hundreds BCD digit.
- dig0  in  4  tens BCD digit.
- dig  in  4  ones BCD digit.
- pix_on  out  1  glyph pixel lit, 2 cycles after the inputs.
- video_on_d  out  1  video_on delayed 2 cycles, for colour-mux alignment.

Behaviour:
- Reset (async, reset=0):
  - Shadow digits = 0.
  - All pipeline registers = 0.
  - pix_on = 0 and video_on_d = 0 immediately, held while reset=0.
- Snapshot: on a clk edge with frame_start=1, shadow_h/t/o <= dig1/dig0/dig. Otherwise the shadow holds.
- Frame_start coincident with a pixel sample: that pixel uses the pre-update shadow.
- Geometry:
  - rx = pixel_x - X0, ry = pixel_y - Y0.
  - in_box = (X0 <= pixel_x < X0+24*S) and (Y0 <= pixel_y < Y0+16*S).
  - Digit slot = rx >> (3+SCALE_LOG2): 0 = hundreds, 1 = tens, 2 = ones, drawn left to right.
  - col = (rx >> SCALE_LOG2) & 7.
  - row = (ry >> SCALE_LOG2) & 15.
- Glyphs: ROM holds 8x16 bitmaps for codes 0..9 using the IBM VGA 8x16 set (ASCII 0x30-0x39). Codes 10..15 render blank (all rows 0x00). Bit 7 of a row byte is col 0.
- Pipeline stage 1 (cycle 1) registers:
  - in_box, video_on
  - selected 4-bit code from the shadow
  - row, col
- Pipeline stage 2 (cycle 2) registers:
  - pix_on = rom[code][row][7-col] & in_box_d & video_on_d1
  - video_on_d
- Latency: exactly 2 clk cycles from input sample to pix_on. Throughput: 1 pixel per clock. No stalls.
- Outside the box, or with video_on=0: pix_on = 0.
- All subtraction is 10-bit. Negative rx/ry wrap to large values, and in_box gates them off.
- Reset mid-frame: the pipeline flushes to 0 and the shadow returns to 0. After reset release, digits read as "000" until the next frame_start.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds slot renders blank when shadow_h = 0.
  - Tens slot renders blank when shadow_h = 0 and shadow_t = 0.
  - Ones slot is never blanked.
  - Blanking is decided in stage 1 by forcing the code to 15.
- Undefined: all three digits are always drawn, including leading zeros.

Test Plan:
- Reset check: reset=0 mid-stream with video_on=1 inside the box -> pix_on=0 and video_on_d=0 immediately. After release with no frame_start, the box shows "000": x=560..575, y=20 (row 2, glyph '0' = 0x7C) -> pix_on=1 at x=562..571, 2 cycles later.
- Digit draw: dig1=1, dig0=2, dig=3, pulse frame_start, scan y=20 (row 2), x=560..575 -> hundreds '1' row 0x18 gives pix_on=1 only for x=566..569, 2-cycle latency.
- Tearing check: change dig1 from 1 to 7 mid-frame without frame_start -> output stays '1'. After the next frame_start it shows '7'. Frame_start coincident with pixel x=566, y=20 -> that pixel still reflects the old digit.
- Box bounds: video_on=1, y=20, x=559 and x=608 -> pix_on=0. y=15 and y=48 -> pix_on=0. video_on=0 inside the box -> pix_on=0.
- Invalid code: dig=4'hC snapshotted -> the ones slot (x=592..607) renders pix_on=0 on all rows.
- LEADING_ZERO_BLANK_EN: digits 0,0,5 -> hundreds and tens slots all 0, ones shows '5'. Digits 0,4,0 -> tens '4' and ones '0' drawn, hundreds blank. Without the macro, "005" draws all three.

Source files
------------

// File: rtl/score_digit_render_if.sv
// Pixel-stream bundle between the sync generator/score counter and the digit renderer.
// master drives pixel position, video flag, frame pulse and digits; slave returns pixel-on.
interface score_digit_render_if;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] dig;
  logic       pix_on;
  logic       video_on_d;

  modport master (
    output video_on, pixel_x, pixel_y, frame_start, dig1, dig0, dig,
    input  pix_on, video_on_d
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, frame_start, dig1, dig0, dig,
    output pix_on, video_on_d
  );
endinterface

// File: rtl/score_digit_render.sv
// Renders a 3-digit BCD score as scaled 8x16 glyphs in a fixed box, 2-cycle pixel latency.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the hundreds and tens slots.
module score_digit_render #(
  parameter int unsigned X0         = 560,
  parameter int unsigned Y0         = 16,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input logic                 clk,
  input logic                 reset,
  score_digit_render_if.slave px_io
);

  localparam int unsigned BoxW = 24 << SCALE_LOG2;
  localparam int unsigned BoxH = 16 << SCALE_LOG2;

  // IBM VGA 8x16 digits, row 0 in the top byte, bit 7 of each row is the leftmost column.
  function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [3:0] r);
    logic [127:0] g;
    logic [127:0] sh;
    case (code)
      4'd0:    g = 128'h00007cc6c6cedef6e6c6c67c00000000;
      4'd1:    g = 128'h00001838781818181818187e00000000;
      4'd2:    g = 128'h00007cc6060c183060c0c6fe00000000;
      4'd3:    g = 128'h00007cc606063c060606c67c00000000;
      4'd4:    g = 128'h00000c1c3c6cccfe0c0c0c1e00000000;
      4'd5:    g = 128'h0000fec0c0c0fc060606c67c00000000;
      4'd6:    g = 128'h00003860c0c0fcc6c6c6c67c00000000;
      4'd7:    g = 128'h0000fec606060c183030303000000000;
      4'd8:    g = 128'h00007cc6c6c67cc6c6c6c67c00000000;
      4'd9:    g = 128'h00007cc6c6c67e0606060c7800000000;
      default: g = '0;
    endcase
    sh = g << {r, 3'b000};
    return sh[127:120];
  endfunction

  logic [3:0] shadow_h_q, shadow_t_q, shadow_o_q;

  // Stage 1
  logic [9:0] rx, ry;
  logic       in_box;
  logic [1:0] slot;
  logic [2:0] col_d;
  logic [3:0] row_d;
  logic [3:0] code_d;

  logic       in_box_q;
  logic       video_on_d1_q;
  logic [3:0] code_q;
  logic [3:0] row_q;
  logic [2:0] col_q;

  // Stage 2
  logic [7:0] glyph_bits;
  logic       pix_on_d;
  logic       pix_on_q;
  logic       video_on_d2_q;

  always_comb begin
    // 10-bit wrap makes left/above-box pixels huge, so one unsigned compare covers both sides.
    rx     = px_io.pixel_x - 10'(X0);
    ry     = px_io.pixel_y - 10'(Y0);
    in_box = (rx < 10'(BoxW)) && (ry < 10'(BoxH));
    slot   = 2'(rx >> (3 + SCALE_LOG2));
    col_d  = 3'(rx >> SCALE_LOG2);
    row_d  = 4'(ry >> SCALE_LOG2);
    case (slot)
      2'd0:    code_d = shadow_h_q;
      2'd1:    code_d = shadow_t_q;
      default: code_d = shadow_o_q;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((slot == 2'd0) && (shadow_h_q == 4'd0)) begin
      code_d = 4'd15;
    end
    if ((slot == 2'd1) && (shadow_h_q == 4'd0) && (shadow_t_q == 4'd0)) begin
      code_d = 4'd15;
    end
`endif
  end

  always_comb begin
    glyph_bits = glyph_row(code_q, row_q);
    pix_on_d   = glyph_bits[3'd7 - col_q] & in_box_q & video_on_d1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_h_q    <= '0;
      shadow_t_q    <= '0;
      shadow_o_q    <= '0;
      in_box_q      <= 1'b0;
      video_on_d1_q <= 1'b0;
      code_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pix_on_q      <= 1'b0;
      video_on_d2_q <= 1'b0;
    end else begin
      // Stage 1 reads the pre-update shadow, so a coincident pixel sees the old digits.
      if (px_io.frame_start) begin
        shadow_h_q <= px_io.dig1;
        shadow_t_q <= px_io.dig0;
        shadow_o_q <= px_io.dig;
      end
      in_box_q      <= in_box;
      video_on_d1_q <= px_io.video_on;
      code_q        <= code_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_on_q      <= pix_on_d;
      video_on_d2_q <= video_on_d1_q;
    end
  end

  assign px_io.pix_on     = pix_on_q;
  assign px_io.video_on_d = video_on_d2_q;

endmodule
